// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] c_default_reset_pc   = 32'd0;
    localparam int          c_default_data_width = 32;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Queue entry at the default instruction width; the top re-declares it per DATA_WIDTH.
    typedef struct packed {
        logic [31:0]                     pc;
        logic [c_default_data_width-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Memory, control and decode-side signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
);
    localparam int c_count_width = $clog2(QUEUE_DEPTH) + 1;

    logic                     fetch_en;
    logic                     imem_req;
    logic [ADDR_WIDTH-1:0]    imem_addr;
    logic [DATA_WIDTH-1:0]    imem_rdata;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     halt;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_instr;
    logic [31:0]              out_pc;
    logic [31:0]              out_pc_plus_one;
    logic [c_count_width-1:0] queue_count;
    logic                     halted;

    modport master (
        input  fetch_en, imem_rdata, redirect_valid, redirect_pc, halt, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_one,
               queue_count, halted
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_valid, redirect_pc, halt, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_one,
               queue_count, halted
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Power-of-two circular FIFO with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int                   c_ptr_width = $clog2(DEPTH);
    localparam logic [c_ptr_width:0] c_depth     = (c_ptr_width + 1)'(DEPTH);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [c_ptr_width-1:0] r_rd_ptr;
    logic [c_ptr_width-1:0] r_wr_ptr;
    logic [c_ptr_width:0]   r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Flush outranks push/pop so a same-cycle return is dropped, not queued.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_width'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_width'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_width + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_width + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Decoupled fetch stage: PC, 1-cycle imem requests, prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 6,
    parameter int          DATA_WIDTH  = 32,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = c_default_reset_pc
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    localparam int                     c_count_width = $clog2(QUEUE_DEPTH) + 1;
    localparam int                     c_entry_width = 32 + DATA_WIDTH;
    localparam logic [c_count_width:0] c_depth       = (c_count_width + 1)'(QUEUE_DEPTH);

    typedef struct packed {
        logic [31:0]           pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t             r_state;
    logic [31:0]              r_fetch_pc;
    logic [31:0]              r_inflight_pc;
    logic                     r_inflight;

    entry_t                   w_push_entry;
    entry_t                   w_head;
    logic [c_count_width-1:0] w_fifo_count;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [c_count_width:0]   w_occupancy;
    logic                     w_run;
    logic                     w_credit;
    logic                     w_out_valid;
    logic                     w_pop;
    logic                     w_halt_take;
    logic                     w_redirect;
    logic                     w_flush;
    logic                     w_issue;
    logic                     w_push;

    assign w_run = (r_state == RUN);

    // Queue slots already spoken for include the one read still in flight.
    assign w_occupancy = {1'b0, w_fifo_count} + {{c_count_width{1'b0}}, r_inflight};
    assign w_credit    = (w_occupancy < c_depth) & ~w_fifo_full;

    assign w_out_valid = ~reset & w_run & ~w_fifo_empty;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_halt_take = bus.halt & w_pop;
    assign w_redirect  = bus.redirect_valid & w_run & ~w_halt_take;
    assign w_flush     = w_redirect | w_halt_take;
    assign w_issue     = ~reset & w_run & bus.fetch_en & ~bus.redirect_valid & w_credit;
    assign w_push      = r_inflight & w_run & ~w_flush;

    assign w_push_entry = {r_inflight_pc, bus.imem_rdata};

    sync_fifo #(
        .WIDTH (c_entry_width),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_push_entry),
        .rdata (w_head),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt_take) begin
                        r_state    <= HALTED;
                        r_inflight <= 1'b0;
                    end else if (w_redirect) begin
                        r_fetch_pc <= bus.redirect_pc;
                        r_inflight <= 1'b0;
                    end else begin
                        r_inflight <= w_issue;
                        if (w_issue) begin
                            r_inflight_pc <= r_fetch_pc;
                            r_fetch_pc    <= pc_inc(r_fetch_pc);
                        end
                    end
                end
                HALTED: begin
                    r_inflight <= 1'b0;
                end
                default: begin
                    r_state    <= RUN;
                    r_inflight <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req        = w_issue;
    assign bus.imem_addr       = r_fetch_pc[ADDR_WIDTH-1:0];
    assign bus.out_valid       = w_out_valid;
    assign bus.out_instr       = w_head.instr;
    assign bus.out_pc          = w_head.pc;
    assign bus.out_pc_plus_one = pc_inc(w_head.pc);
    assign bus.queue_count     = reset ? '0 : w_fifo_count;
    assign bus.halted          = ~reset & (r_state == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Vector table plus directed sequences with an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .QUEUE_DEPTH(4)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH  (6),
        .DATA_WIDTH  (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        fen;
        logic        rdy;
        logic        req;
        logic [5:0]  addr;
        logic        ov;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return 32'hA000_0000 | {26'd0, a};
    endfunction

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got pc %h expected no output", bus.out_pc);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                check("sb_pc", bus.out_pc, e);
                check("sb_instr", bus.out_instr, mem_word(e[5:0]));
                check("sb_pc_plus_one", bus.out_pc_plus_one, e + 32'd1);
            end
        end
    end

    task automatic add_vec(input logic rst, input logic fen, input logic rdy, input logic req,
                           input logic [5:0] addr, input logic ov, input logic [31:0] pc,
                           input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.fen = fen; v.rdy = rdy; v.req = req;
        v.addr = addr; v.ov = ov; v.pc = pc; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) $display("FAIL %s_drain: got %0d pending expected 0", name, sb_q.size());
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.halt = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.fetch_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.halt = 1'b0;

        // Stall from reset, saturate at 4, then release.
        add_vec(1, 1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 1, 0, 0, 0, 0);
        add_vec(0, 1, 0, 1, 1, 0, 0, 0);
        add_vec(0, 1, 0, 1, 2, 1, 0, 1);
        add_vec(0, 1, 0, 1, 3, 1, 0, 2);
        add_vec(0, 1, 0, 0, 0, 1, 0, 3);
        for (int i = 0; i < 5; i++) add_vec(0, 1, 0, 0, 0, 1, 0, 4);
        add_vec(0, 1, 1, 0, 0, 1, 0, 4);
        add_vec(0, 1, 1, 1, 4, 1, 1, 3);
        add_vec(0, 1, 1, 1, 5, 1, 2, 2);
        add_vec(0, 1, 1, 1, 6, 1, 3, 2);
        // Latency and streaming with decode always ready.
        add_vec(1, 1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 1, 1, 0, 0, 0, 0);
        add_vec(0, 1, 1, 1, 1, 0, 0, 0);
        add_vec(0, 1, 1, 1, 2, 1, 0, 1);
        add_vec(0, 1, 1, 1, 3, 1, 1, 1);
        add_vec(0, 1, 1, 1, 4, 1, 2, 1);
        add_vec(0, 1, 1, 1, 5, 1, 3, 1);
        // Reset with three queued and one in flight, then restart at RESET_PC.
        add_vec(1, 1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 1, 0, 0, 0, 0);
        add_vec(0, 1, 0, 1, 1, 0, 0, 0);
        add_vec(0, 1, 0, 1, 2, 1, 0, 1);
        add_vec(0, 1, 0, 1, 3, 1, 0, 2);
        add_vec(0, 1, 0, 0, 0, 1, 0, 3);
        add_vec(1, 1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst;
            bus.fetch_en = vecs[i].fen;
            bus.out_ready = vecs[i].rdy;
            if (vecs[i].rdy && vecs[i].ov) sb_q.push_back(vecs[i].pc);
            @(negedge clk);
            check("vec_imem_req", bus.imem_req, vecs[i].req);
            if (vecs[i].req) check("vec_imem_addr", bus.imem_addr, vecs[i].addr);
            check("vec_out_valid", bus.out_valid, vecs[i].ov);
            if (vecs[i].ov) check("vec_out_pc", bus.out_pc, vecs[i].pc);
            check("vec_queue_count", bus.queue_count, vecs[i].cnt);
            check("vec_halted", bus.halted, 1'b0);
        end

        // Redirect while the queue holds pcs 3..6.
        bus.fetch_en = 1'b1;
        do_reset();
        bus.out_ready = 1'b1;
        for (int p = 0; p < 3; p++) sb_q.push_back(p);
        wait_drain("stream_drain");
        bus.out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("full_count", bus.queue_count, 4);
        check("full_head_pc", bus.out_pc, 3);
        check("full_no_req", bus.imem_req, 0);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd20;
        @(negedge clk);
        check("redirect_no_req", bus.imem_req, 0);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int p = 20; p < 23; p++) sb_q.push_back(p);
        @(negedge clk);
        check("redir1_valid", bus.out_valid, 0);
        check("redir1_count", bus.queue_count, 0);
        check("redir1_req", bus.imem_req, 1);
        check("redir1_addr", bus.imem_addr, 20);
        @(posedge clk); #1;
        @(negedge clk);
        check("redir2_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("redir3_valid", bus.out_valid, 1);
        check("redir3_pc", bus.out_pc, 20);
        @(posedge clk); #1;
        wait_drain("redirect_drain");
        bus.out_ready = 1'b0;

        // HALT with head pc=5, redirect in the same cycle.
        do_reset();
        bus.out_ready = 1'b1;
        for (int p = 0; p < 5; p++) sb_q.push_back(p);
        wait_drain("prehalt_drain");
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("halt_head_valid", bus.out_valid, 1);
        check("halt_head_pc", bus.out_pc, 5);
        @(posedge clk); #1;
        bus.halt = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd40;
        bus.out_ready = 1'b1;
        sb_q.push_back(32'd5);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.halt = 1'b0;
            bus.redirect_valid = i[0];
            @(negedge clk);
            check("halted_flag", bus.halted, 1);
            check("halted_valid", bus.out_valid, 0);
            check("halted_req", bus.imem_req, 0);
        end
        bus.redirect_valid = 1'b0;
        wait_drain("halt_drain");

        // Address wrap at 63 -> 64, and 32-bit PC wrap.
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd62;
        @(negedge clk);
        check("wrap_redirect_req", bus.imem_req, 0);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int p = 62; p < 66; p++) sb_q.push_back(p);
        @(negedge clk);
        check("wrap_addr62", bus.imem_addr, 62);
        @(posedge clk); #1;
        @(negedge clk);
        check("wrap_addr63", bus.imem_addr, 63);
        @(posedge clk); #1;
        @(negedge clk);
        check("wrap_req64", bus.imem_req, 1);
        check("wrap_addr64", bus.imem_addr, 0);
        @(posedge clk); #1;
        wait_drain("wrap_drain");
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        sb_q.push_back(32'hFFFF_FFFF);
        sb_q.push_back(32'd0);
        sb_q.push_back(32'd1);
        wait_drain("pcwrap_drain");
        bus.out_ready = 1'b0;

        // fetch_en low: nothing issues; one enabled cycle still completes.
        bus.fetch_en = 1'b0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fen_off_req", bus.imem_req, 0);
            check("fen_off_valid", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        bus.fetch_en = 1'b1;
        @(negedge clk);
        check("fen_on_req", bus.imem_req, 1);
        check("fen_on_addr", bus.imem_addr, 0);
        @(posedge clk); #1;
        bus.fetch_en = 1'b0;
        sb_q.push_back(32'd0);
        @(negedge clk);
        check("fen_pending_req", bus.imem_req, 0);
        check("fen_pending_count", bus.queue_count, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fen_late_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("fen_after_valid", bus.out_valid, 0);
        check("fen_after_count", bus.queue_count, 0);
        check("fen_after_req", bus.imem_req, 0);

        @(posedge clk); #1;
        check("sb_final_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
